multdiv_stall_ctrl: RTL and testbench

//  Sequencer that shares the iterative multiply/divide unit with the execute stage of the pipelined processor.

---
 rtl/multdiv_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_multdiv_stall_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_stall_ctrl.sv
// Multiply/divide sequencer: issues ops to the shared unit, stalls the pipe,
// and returns one writeback beat. Option macro: MULTDIV_TIMEOUT_EN (watchdog).
module multdiv_stall_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int STATUS_REG       = 30,
  parameter int MULT_EXC_CODE    = 4,
  parameter int DIV_EXC_CODE     = 5,
  parameter int TIMEOUT_EXC_CODE = 6,
  parameter int TIMEOUT_CYCLES   = 40
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_mult,
  input  logic                      issue_div,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  input  logic                      flush,
  output logic                      md_ctrl_mult,
  output logic                      md_ctrl_div,
  output logic [DATA_WIDTH-1:0]     md_a,
  output logic [DATA_WIDTH-1:0]     md_b,
  input  logic [DATA_WIDTH-1:0]     md_result,
  input  logic                      md_exception,
  input  logic                      md_ready,
  output logic                      stall,
  output logic                      busy,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic                      wb_exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic                      op_mult;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic                      issue;

  assign issue = issue_mult | issue_div;

  // Freeze the pipe from the issue cycle until the result is ready
  assign stall = (state == IDLE && issue)
               | (state == START)
               | (state == WAIT);

  assign busy = (state != IDLE);

`ifdef MULTDIV_TIMEOUT_EN
  logic [5:0] wait_cnt;
  logic       expire;

  assign expire = (wait_cnt == 6'(TIMEOUT_CYCLES - 1));
`endif

  // Sequencer FSM with registered unit strobes and writeback beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_mult      <= 1'b0;
      dest_q       <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_a         <= '0;
      md_b         <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_reg       <= '0;
      wb_exception <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (issue) begin
              state        <= START;
              op_mult      <= issue_mult;
              dest_q       <= dest_reg;
              md_a         <= operand_a;
              md_b         <= operand_b;
              md_ctrl_mult <= issue_mult;
              md_ctrl_div  <= ~issue_mult;
            end
          end
          START: begin
            state <= WAIT;
`ifdef MULTDIV_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
          WAIT: begin
            if (md_ready) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              if (md_exception) begin
                wb_data      <= op_mult ? DATA_WIDTH'(MULT_EXC_CODE)
                                        : DATA_WIDTH'(DIV_EXC_CODE);
                wb_reg       <= REG_ADDR_WIDTH'(STATUS_REG);
                wb_exception <= 1'b1;
              end else begin
                wb_data      <= md_result;
                wb_reg       <= dest_q;
                wb_exception <= 1'b0;
              end
            end
`ifdef MULTDIV_TIMEOUT_EN
            else if (expire) begin
              state        <= DONE;
              wb_valid     <= 1'b1;
              wb_data      <= DATA_WIDTH'(TIMEOUT_EXC_CODE);
              wb_reg       <= REG_ADDR_WIDTH'(STATUS_REG);
              wb_exception <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 6'd1;
            end
`endif
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Scoreboard bench for multdiv_stall_ctrl: directed ops, expected
// writebacks queued at issue and checked by an independent monitor.
module tb_multdiv_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_mult, issue_div, flush;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  dest_reg;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_a, md_b, md_result;
  logic        md_exception, md_ready;
  logic        stall, busy, wb_valid, wb_exception;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } wb_t;

  wb_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  stall_cnt   = 0;
  int  wb_beats    = 0;
  int  mult_pulses = 0;
  int  div_pulses  = 0;

  multdiv_stall_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .issue_mult   (issue_mult),
    .issue_div    (issue_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .dest_reg     (dest_reg),
    .flush        (flush),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_a         (md_a),
    .md_b         (md_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_exception (wb_exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each writeback beat
  always @(negedge clock) begin
    if (!reset) begin
      if (stall) stall_cnt++;
      if (md_ctrl_mult) mult_pulses++;
      if (md_ctrl_div) div_pulses++;
      if (wb_valid) begin
        wb_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 32'd1, 32'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_reg", 32'(wb_reg), 32'(e.rd));
          chk("wb_exc", 32'(wb_exception), 32'(e.exc));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic im, input logic id,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input int dly,
                       input logic exc, input logic [31:0] res,
                       input logic [31:0] ed, input logic [4:0] er,
                       input logic ee, input logic exp_m);
    int b0, m0, d0;
    wb_t e;
    e.data = ed; e.rd = er; e.exc = ee;
    exp_q.push_back(e);
    b0 = wb_beats; m0 = mult_pulses; d0 = div_pulses;
    stall_cnt = 0;
    issue_mult = im; issue_div = id;
    operand_a = a; operand_b = b; dest_reg = dst;
    @(negedge clock);
    chk("stall_issue", 32'(stall), 32'd1);
    step();
    issue_mult = 0; issue_div = 0;
    operand_a = '0; operand_b = '0;
    chk("md_a", md_a, a);
    chk("md_b", md_b, b);
    repeat (dly) step();
    md_ready = 1; md_exception = exc; md_result = res;
    step();
    md_ready = 0; md_exception = 0; md_result = '0;
    step();
    chk("stall_cycles", 32'(stall_cnt), 32'(dly + 2));
    chk("wb_beats", 32'(wb_beats - b0), 32'd1);
    chk("mult_pulse", 32'(mult_pulses - m0), exp_m ? 32'd1 : 32'd0);
    chk("div_pulse", 32'(div_pulses - d0), exp_m ? 32'd0 : 32'd1);
  endtask

  initial begin
    int b0;
    reset = 1; flush = 0;
    issue_mult = 0; issue_div = 0;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    md_result = '0; md_exception = 0; md_ready = 0;
    repeat (2) step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    reset = 0;
    step();

    do_op(1, 0, 32'd3, 32'd4, 5'd7, 32, 0, 32'd12,
          32'd12, 5'd7, 0, 1);
    do_op(0, 1, 32'd5, 32'd0, 5'd9, 5, 1, 32'hffff_ffff,
          32'd5, 5'd30, 1, 0);
    do_op(1, 1, 32'h4000_0000, 32'd4, 5'd3, 2, 1, 32'd0,
          32'd4, 5'd30, 1, 1);
    chk("hold_data", wb_data, 32'd4);

    // Flush in WAIT cycle 10, late ready at cycle 20
    b0 = wb_beats;
    issue_mult = 1; operand_a = 32'd1; operand_b = 32'd2;
    dest_reg = 5'd5;
    step();
    issue_mult = 0;
    repeat (9) step();
    chk("flush_busy_pre", 32'(busy), 32'd1);
    flush = 1;
    step();
    flush = 0;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (9) step();
    md_ready = 1; md_result = 32'hdead;
    step();
    md_ready = 0; md_result = '0;
    repeat (2) step();
    chk("flush_no_wb", 32'(wb_beats - b0), 32'd0);
    do_op(1, 0, 32'd6, 32'd7, 5'd2, 1, 0, 32'd42,
          32'd42, 5'd2, 0, 1);

`ifdef MULTDIV_TIMEOUT_EN
    begin
      wb_t e;
      int cyc;
      e.data = 32'd6; e.rd = 5'd30; e.exc = 1;
      exp_q.push_back(e);
      issue_mult = 1; dest_reg = 5'd8;
      cyc = 0;
      while (cyc < 60) begin
        step();
        issue_mult = 0;
        cyc++;
        if (wb_valid) break;
      end
      chk("timeout_cycle", 32'(cyc), 32'd42);
      step();
    end
`else
    stall_cnt = 0;
    issue_mult = 1; dest_reg = 5'd8;
    step();
    issue_mult = 0;
    repeat (199) step();
    chk("no_timeout_stall", 32'(stall_cnt), 32'd200);
    flush = 1;
    step();
    flush = 0;
    chk("no_timeout_flush", 32'(busy), 32'd0);
`endif

    // Asynchronous reset while in WAIT
    issue_div = 1; operand_a = 32'd7; operand_b = 32'd1;
    dest_reg = 5'd4;
    step();
    issue_div = 0;
    repeat (4) step();
    #2;
    reset = 1;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wbv", 32'(wb_valid), 32'd0);
    step();
    reset = 0;
    step();
    do_op(0, 1, 32'd12, 32'd2, 5'd11, 3, 0, 32'd6,
          32'd6, 5'd11, 0, 0);

    repeat (3) step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
